mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store sequencer between the MEM pipeline stage and the single-ported, word-organised data memory. It accepts one byte, halfword or word access at a time and drives the memory's word address, byte enables and write data. Accesses that cross a word boundary are split into two word transactions and merged, and the pipeline is stalled until the access completes. Load results go to the load-extension stage as a 32-bit word plus a 2-bit byte select.

## Interface
- SPLIT_EN, 1: 1 = split word-crossing accesses; 0 = flag them as errors with no memory access.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- Req  in  1  access request; held stable by pipeline until Done
- We  in  1  1 = store, 0 = load
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal
- Addr  in  32  byte address
- WData  in  32  store data, right-aligned
- Stall  out  1  Req & ~Done (combinational)
- Done  out  1  one-cycle completion pulse
- Err  out  1  pulses with Done for illegal Size, or for a crossing access when SPLIT_EN=0
- RdWord  out  32  load word for extension, valid while Done=1
- RdByteSel  out  2  byte select for extension, valid while Done=1
- MemEn  out  1  memory access strobe
- MemWordAddr  out  30  word address
- MemBe  out  4  byte write enables; 0000 on loads
- MemWData  out  32  lane-shifted write data
- MemRData  in  32  read word
- MemReady  in  1  access complete this cycle (read data valid / write committed)

## Operation
- States: IDLE, ACC1, ACC2, DONE.
- Offset o = Addr[1:0]; A = Addr[31:2].
- Cross = (Size=01 & o=3) | (Size=10 & o≠0).
- **IDLE**
  - On Req: latch We, Size, Addr, WData.
  - Illegal Size, or Cross with SPLIT_EN=0: go to DONE with Err.
  - Otherwise go to ACC1.
- **ACC1**
  - MemEn=1, MemWordAddr=A.
  - Hold until MemReady.
  - On MemReady: capture MemRData as lo; go to ACC2 if Cross, else DONE.
- **ACC2**
  - MemEn=1, MemWordAddr=A+1 mod 2^30 (0x3FFFFFFF wraps to 0).
  - On MemReady: capture hi; go to DONE.
- **DONE**
  - Done=1 for one cycle, then IDLE.
- Store enables, first word:
  - byte: 0001<<o
  - half: (0011<<o)[3:0]
  - word: (1111<<o)[3:0]
- Store enables, second word: the bits shifted out above bit 3 (half o=3 → 0001; word → 1111>>(4−o)).
- Store data: first word WData<<(8·o); second word WData>>(8·(4−o)).
- Load, no Cross: RdWord=lo, RdByteSel=o.
- Load, Cross: RdWord={hi,lo}>>(8·o) truncated to 32 bits; RdByteSel=00.
- RdWord, RdByteSel and Err are registered and meaningful only while Done=1.
- Req deasserting mid-transaction is ignored; the transaction completes and Done still pulses.
- Reset in any state forces IDLE and abandons the access. A second-half store may be lost.

## Timing
- Reset values:
  - State=IDLE
  - MemEn=0, MemBe=0000, MemWordAddr=0, MemWData=0
  - Done=0, Err=0, RdWord=0, RdByteSel=00
- MemEn, MemWordAddr, MemBe and MemWData are registered and change only on state transitions.
- Latency from Req sampled in IDLE (cycle 0), zero-wait memory:
  - aligned / non-crossing: ACC1 in cycle 1, Done in cycle 2
  - crossing: ACC2 in cycle 2, Done in cycle 3
- Each memory wait cycle adds one cycle.
- Illegal Size: Done+Err in cycle 1; MemEn never asserted.
- Back-to-back requests: the pipeline advances on Done, and the next Req is sampled in the following IDLE cycle. This gives one idle cycle between accesses.
- MemReady is ignored outside ACC1/ACC2.

## Test plan
- **Aligned word load:** Addr=0x100, mem[0x40]=0xDEADBEEF, MemReady tied 1 → MemWordAddr=0x40, Done in cycle 2, RdWord=0xDEADBEEF, RdByteSel=00.
- **Crossing halfword load:** Addr=0x103, mem[0x40]=0xAABBCCDD, mem[0x41]=0x11223344 → two accesses to 0x40 then 0x41, RdWord[15:0]=0x44AA, RdByteSel=00, Done in cycle 3.
- **Misaligned word store:** Addr=0x202, WData=0x12345678 → MemBe=1100 with MemWData=0x56780000 at 0x80, then MemBe=0011 with MemWData=0x00001234 at 0x81.
- **Wait states and wrap:** byte store at Addr=0xFFFFFFFF with MemReady low for 3 cycles → MemBe=1000 at 0x3FFFFFFF, Stall high throughout, Done in cycle 5.
- **Word load at Addr=0xFFFFFFFD:** second access goes to word address 0.
- **Errors:** Size=11 → Err with Done in cycle 1, MemEn stays 0. SPLIT_EN=0 with a crossing word load → Err, no MemEn.
- **Reset mid-operation:** assert rst_n low during ACC2 → all outputs return to reset values immediately; the next Req proceeds normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Load/store bus between the MEM stage, the sequencer and the data memory.
// The slave modport is the sequencer; master is the pipeline + memory side.
interface mem_access_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rd_word;
  logic [1:0]  rd_byte_sel;
  logic        mem_en;
  logic [29:0] mem_word_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req, we, size, addr, wdata,
    input  mem_rdata, mem_ready,
    output stall, done, err,
    output rd_word, rd_byte_sel,
    output mem_en, mem_word_addr,
    output mem_be, mem_wdata
  );

  modport master (
    output req, we, size, addr, wdata,
    output mem_rdata, mem_ready,
    input  stall, done, err,
    input  rd_word, rd_byte_sel,
    input  mem_en, mem_word_addr,
    input  mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for a word-organised data memory.
// Word-crossing accesses become two word transactions that are merged.
module mem_access_ctrl #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_off;
  logic        r_cross;
  logic [31:0] r_lo;
  logic [3:0]  r_be_hi;
  logic [31:0] r_wd_hi;
  logic        r_mem_en;
  logic [29:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rd_word;
  logic [1:0]  r_rd_sel;

  logic [1:0]  w_off;
  logic        w_cross;
  logic        w_illegal;
  logic [3:0]  w_base;
  logic [7:0]  w_be8;
  logic [63:0] w_wd64;
  logic [31:0] w_merge;

  // Lane masks/data are shifted across a 2-word window; the upper
  // half is what the second transaction writes.
  always_comb begin
    w_off     = bus.addr[1:0];
    w_illegal = (bus.size == 2'b11);
    w_cross   = ((bus.size == 2'b01) && (w_off == 2'd3))
             || ((bus.size == 2'b10) && (w_off != 2'd0));
    w_base    = 4'b1111;
    unique case (bus.size)
      2'b00:   w_base = 4'b0001;
      2'b01:   w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
    w_be8  = {4'b0000, w_base} << w_off;
    w_wd64 = {32'h0, bus.wdata} << {w_off, 3'b000};
  end

  always_comb begin
    w_merge = r_lo;
    unique case (r_off)
      2'd1:    w_merge = {bus.mem_rdata[7:0],  r_lo[31:8]};
      2'd2:    w_merge = {bus.mem_rdata[15:0], r_lo[31:16]};
      2'd3:    w_merge = {bus.mem_rdata[23:0], r_lo[31:24]};
      default: w_merge = r_lo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_off       <= 2'd0;
      r_cross     <= 1'b0;
      r_lo        <= 32'h0;
      r_be_hi     <= 4'h0;
      r_wd_hi     <= 32'h0;
      r_mem_en    <= 1'b0;
      r_mem_addr  <= 30'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rd_word   <= 32'h0;
      r_rd_sel    <= 2'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_off   <= w_off;
            r_cross <= w_cross;
            if (w_illegal || (w_cross && !SPLIT_EN)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ACC1;
              r_mem_en    <= 1'b1;
              r_mem_addr  <= bus.addr[31:2];
              r_mem_be    <= bus.we ? w_be8[3:0] : 4'h0;
              r_be_hi     <= bus.we ? w_be8[7:4] : 4'h0;
              r_mem_wdata <= w_wd64[31:0];
              r_wd_hi     <= w_wd64[63:32];
            end
          end
        end
        ACC1: begin
          if (bus.mem_ready) begin
            r_lo <= bus.mem_rdata;
            if (r_cross) begin
              r_state     <= ACC2;
              r_mem_addr  <= r_mem_addr + 30'd1;
              r_mem_be    <= r_be_hi;
              r_mem_wdata <= r_wd_hi;
            end else begin
              r_state   <= DONE;
              r_mem_en  <= 1'b0;
              r_mem_be  <= 4'h0;
              r_done    <= 1'b1;
              r_rd_word <= bus.mem_rdata;
              r_rd_sel  <= r_off;
            end
          end
        end
        ACC2: begin
          if (bus.mem_ready) begin
            r_state   <= DONE;
            r_mem_en  <= 1'b0;
            r_mem_be  <= 4'h0;
            r_done    <= 1'b1;
            r_rd_word <= w_merge;
            r_rd_sel  <= 2'd0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.stall         = bus.req & ~r_done;
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.rd_word       = r_rd_word;
  assign bus.rd_byte_sel   = r_rd_sel;
  assign bus.mem_en        = r_mem_en;
  assign bus.mem_word_addr = r_mem_addr;
  assign bus.mem_be        = r_mem_be;
  assign bus.mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: split and non-split instances
// against a byte-writable word memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if b1 ();
  mem_access_ctrl_if b0 ();

  mem_access_ctrl #(.SPLIT_EN(1'b1)) u_split (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  mem_access_ctrl #(.SPLIT_EN(1'b0)) u_nosplit (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0)
  );

  logic [31:0] mem [logic [29:0]];

  always @(negedge clk) begin
    if (mem.exists(b1.mem_word_addr))
      b1.mem_rdata = mem[b1.mem_word_addr];
    else
      b1.mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (rst_n && b1.mem_en && b1.mem_ready) begin
      logic [31:0] w;
      w = mem.exists(b1.mem_word_addr) ? mem[b1.mem_word_addr] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (b1.mem_be[i]) w[i*8 +: 8] = b1.mem_wdata[i*8 +: 8];
      mem[b1.mem_word_addr] = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req1(input logic we, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wd);
    b1.req   = 1'b1;
    b1.we    = we;
    b1.size  = size;
    b1.addr  = addr;
    b1.wdata = wd;
  endtask

  initial begin
    b1.req = 1'b0; b1.we = 1'b0; b1.size = 2'b00;
    b1.addr = 32'h0; b1.wdata = 32'h0; b1.mem_ready = 1'b1;
    b0.req = 1'b0; b0.we = 1'b0; b0.size = 2'b00;
    b0.addr = 32'h0; b0.wdata = 32'h0; b0.mem_ready = 1'b1;
    b0.mem_rdata = 32'hCAFEF00D;
    mem[30'h40] = 32'hDEADBEEF;
    mem[30'h0]  = 32'h55667788;

    @(negedge clk);
    #1;
    chk("rst_en",    {31'h0, b1.mem_en}, 32'h0);
    chk("rst_addr",  {2'b0, b1.mem_word_addr}, 32'h0);
    chk("rst_be",    {28'h0, b1.mem_be}, 32'h0);
    chk("rst_wd",    b1.mem_wdata, 32'h0);
    chk("rst_done",  {31'h0, b1.done}, 32'h0);
    chk("rst_err",   {31'h0, b1.err}, 32'h0);
    chk("rst_rdw",   b1.rd_word, 32'h0);
    chk("rst_sel",   {30'h0, b1.rd_byte_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // aligned word load
    req1(1'b0, 2'b10, 32'h100, 32'h0);
    #1;
    chk("wl_stall0", {31'h0, b1.stall}, 32'h1);
    step();
    chk("wl_en1",   {31'h0, b1.mem_en}, 32'h1);
    chk("wl_addr1", {2'b0, b1.mem_word_addr}, 32'h40);
    chk("wl_be1",   {28'h0, b1.mem_be}, 32'h0);
    chk("wl_done1", {31'h0, b1.done}, 32'h0);
    step();
    chk("wl_done2", {31'h0, b1.done}, 32'h1);
    chk("wl_err2",  {31'h0, b1.err}, 32'h0);
    chk("wl_rdw",   b1.rd_word, 32'hDEADBEEF);
    chk("wl_sel",   {30'h0, b1.rd_byte_sel}, 32'h0);
    chk("wl_stall2", {31'h0, b1.stall}, 32'h0);
    chk("wl_en2",   {31'h0, b1.mem_en}, 32'h0);
    b1.req = 1'b0;
    step();
    chk("wl_done3", {31'h0, b1.done}, 32'h0);

    // crossing halfword load
    mem[30'h40] = 32'hAABBCCDD;
    mem[30'h41] = 32'h11223344;
    req1(1'b0, 2'b01, 32'h103, 32'h0);
    step();
    chk("hl_addr1", {2'b0, b1.mem_word_addr}, 32'h40);
    chk("hl_en1",   {31'h0, b1.mem_en}, 32'h1);
    step();
    chk("hl_addr2", {2'b0, b1.mem_word_addr}, 32'h41);
    chk("hl_en2",   {31'h0, b1.mem_en}, 32'h1);
    chk("hl_done2", {31'h0, b1.done}, 32'h0);
    step();
    chk("hl_done3", {31'h0, b1.done}, 32'h1);
    chk("hl_rdw",   b1.rd_word, 32'h223344AA);
    chk("hl_sel",   {30'h0, b1.rd_byte_sel}, 32'h0);
    b1.req = 1'b0;
    step();

    // non-crossing byte load keeps the byte select
    req1(1'b0, 2'b00, 32'h102, 32'h0);
    step();
    step();
    chk("bl_done", {31'h0, b1.done}, 32'h1);
    chk("bl_rdw",  b1.rd_word, 32'hAABBCCDD);
    chk("bl_sel",  {30'h0, b1.rd_byte_sel}, 32'h2);
    b1.req = 1'b0;
    step();

    // misaligned word store
    req1(1'b1, 2'b10, 32'h202, 32'h12345678);
    step();
    chk("ws_addr1", {2'b0, b1.mem_word_addr}, 32'h80);
    chk("ws_be1",   {28'h0, b1.mem_be}, 32'hC);
    chk("ws_wd1",   b1.mem_wdata, 32'h56780000);
    step();
    chk("ws_addr2", {2'b0, b1.mem_word_addr}, 32'h81);
    chk("ws_be2",   {28'h0, b1.mem_be}, 32'h3);
    chk("ws_wd2",   b1.mem_wdata, 32'h00001234);
    step();
    chk("ws_done", {31'h0, b1.done}, 32'h1);
    chk("ws_m80",  mem[30'h80], 32'h56780000);
    chk("ws_m81",  mem[30'h81], 32'h00001234);
    b1.req = 1'b0;
    step();

    // byte store at top address with three wait cycles
    b1.mem_ready = 1'b0;
    req1(1'b1, 2'b00, 32'hFFFFFFFF, 32'h000000A5);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("bs_stall%0d", c), {31'h0, b1.stall}, 32'h1);
      chk($sformatf("bs_en%0d", c), {31'h0, b1.mem_en}, 32'h1);
      chk($sformatf("bs_done%0d", c), {31'h0, b1.done}, 32'h0);
      if (c == 4) b1.mem_ready = 1'b1;
    end
    chk("bs_addr", {2'b0, b1.mem_word_addr}, 32'h3FFFFFFF);
    chk("bs_be",   {28'h0, b1.mem_be}, 32'h8);
    chk("bs_wd",   b1.mem_wdata, 32'hA5000000);
    step();
    chk("bs_done5", {31'h0, b1.done}, 32'h1);
    chk("bs_mem",   mem[30'h3FFFFFFF], 32'hA5000000);
    b1.req = 1'b0;
    step();

    // crossing word load wrapping to word 0
    req1(1'b0, 2'b10, 32'hFFFFFFFD, 32'h0);
    step();
    chk("wr_addr1", {2'b0, b1.mem_word_addr}, 32'h3FFFFFFF);
    step();
    chk("wr_addr2", {2'b0, b1.mem_word_addr}, 32'h0);
    chk("wr_en2",   {31'h0, b1.mem_en}, 32'h1);
    step();
    chk("wr_done", {31'h0, b1.done}, 32'h1);
    chk("wr_rdw",  b1.rd_word, 32'h88A50000);
    b1.req = 1'b0;
    step();

    // illegal size
    req1(1'b0, 2'b11, 32'h100, 32'h0);
    step();
    chk("il_done", {31'h0, b1.done}, 32'h1);
    chk("il_err",  {31'h0, b1.err}, 32'h1);
    chk("il_en",   {31'h0, b1.mem_en}, 32'h0);
    b1.req = 1'b0;
    step();
    chk("il_err2", {31'h0, b1.err}, 32'h0);
    chk("il_en2",  {31'h0, b1.mem_en}, 32'h0);

    // split disabled: crossing word load errors, aligned load works
    b0.req = 1'b1; b0.we = 1'b0; b0.size = 2'b10; b0.addr = 32'h101;
    step();
    chk("ns_done", {31'h0, b0.done}, 32'h1);
    chk("ns_err",  {31'h0, b0.err}, 32'h1);
    chk("ns_en",   {31'h0, b0.mem_en}, 32'h0);
    b0.req = 1'b0;
    step();
    b0.req = 1'b1; b0.addr = 32'h100;
    step();
    chk("na_en", {31'h0, b0.mem_en}, 32'h1);
    step();
    chk("na_done", {31'h0, b0.done}, 32'h1);
    chk("na_err",  {31'h0, b0.err}, 32'h0);
    chk("na_rdw",  b0.rd_word, 32'hCAFEF00D);
    b0.req = 1'b0;
    step();

    // reset during the second half of a crossing load
    req1(1'b0, 2'b01, 32'h103, 32'h0);
    step();
    step();
    chk("rs_en_pre", {31'h0, b1.mem_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rs_en",   {31'h0, b1.mem_en}, 32'h0);
    chk("rs_addr", {2'b0, b1.mem_word_addr}, 32'h0);
    chk("rs_done", {31'h0, b1.done}, 32'h0);
    chk("rs_rdw",  b1.rd_word, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req1(1'b0, 2'b10, 32'h100, 32'h0);
    step();
    chk("rs_addr1", {2'b0, b1.mem_word_addr}, 32'h40);
    step();
    chk("rs_done2", {31'h0, b1.done}, 32'h1);
    chk("rs_rdw2",  b1.rd_word, 32'hAABBCCDD);
    b1.req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
